// File: rtl/rx_credit_ctrl.sv
// Receive-side flow control for the SpaceWire RX buffer: tracks buffer occupancy and
// credit granted to the far end, and requests an FCT whenever another 8-char credit fits.
//
//   state    | meaning
//   ---------|------------------------------------------------------------
//   DISABLED | link down; credit forced to 0, no FCT requests
//   IDLE     | link up; waiting until buffer space allows another credit
//   REQUEST  | fct_request high until TX reports the FCT was sent
module rx_credit_ctrl #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_CREDIT = 56
) (
  input  logic                  negedge_clk,
  input  logic                  rx_reset,
  input  logic                  link_enable,
  input  logic                  rx_buffer_write,
  input  logic                  rx_buffer_read,
  input  logic                  fct_sent,
  output logic                  fct_request,
  output logic [5:0]            credit_outstanding,
  output logic [ADDR_WIDTH:0]   fifo_used,
  output logic                  rx_buffer_full,
  output logic                  rx_buffer_empty,
  output logic                  credit_error
);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_IDLE,
    ST_REQUEST
  } state_t;

  state_t state, state_nxt;

  logic [15:0]         free_space;
  logic [15:0]         credit_plus8;
  logic                eligible;
  logic                grant;
  logic                overflow;
  logic                credit_dec;
  logic                error_nxt;
  logic [ADDR_WIDTH:0] fifo_nxt;
  logic [6:0]          credit_sum;
  logic [5:0]          credit_nxt;

  assign rx_buffer_full  = (fifo_used == (ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign rx_buffer_empty = (fifo_used == '0);

  // Eligibility looks only at registered occupancy and credit.
  assign free_space   = 16'(FIFO_DEPTH) - 16'(fifo_used);
  assign credit_plus8 = 16'(credit_outstanding) + 16'd8;
  assign eligible     = (free_space >= credit_plus8) && (credit_plus8 <= 16'(MAX_CREDIT));

  always_ff @(posedge negedge_clk) begin
    if (rx_reset) begin
      state <= ST_DISABLED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fct_request = 1'b0;
    unique case (state)
      ST_DISABLED: begin
        if (link_enable) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (eligible) state_nxt = ST_REQUEST;
      end
      ST_REQUEST: begin
        fct_request = 1'b1;
        if (fct_sent) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_DISABLED;
    endcase
    if (!link_enable) state_nxt = ST_DISABLED;
  end

  always_comb begin
    grant      = (state == ST_REQUEST) && fct_sent && link_enable;
    // A simultaneous read frees the slot first, so a write into a full buffer is only
    // an overflow when no read accompanies it.
    overflow   = rx_buffer_write && rx_buffer_full && !rx_buffer_read;
    credit_dec = rx_buffer_write && (credit_outstanding != 6'd0) && !overflow;
    error_nxt  = overflow
               || (rx_buffer_write && (credit_outstanding == 6'd0))
               || (rx_buffer_write && !link_enable);

    fifo_nxt = fifo_used;
    if (rx_buffer_write && !rx_buffer_read && !rx_buffer_full) begin
      fifo_nxt = fifo_used + 1'b1;
    end else if (rx_buffer_read && !rx_buffer_write && !rx_buffer_empty) begin
      fifo_nxt = fifo_used - 1'b1;
    end

    credit_sum = {1'b0, credit_outstanding}
               + (grant ? 7'd8 : 7'd0)
               - (credit_dec ? 7'd1 : 7'd0);
    if (credit_sum > 7'(MAX_CREDIT)) begin
      credit_sum = 7'(MAX_CREDIT);
    end
    credit_nxt = credit_sum[5:0];
    if (!link_enable || (state == ST_DISABLED)) begin
      credit_nxt = 6'd0;
    end
  end

  always_ff @(posedge negedge_clk) begin
    if (rx_reset) begin
      fifo_used          <= '0;
      credit_outstanding <= 6'd0;
      credit_error       <= 1'b0;
    end else begin
      fifo_used          <= fifo_nxt;
      credit_outstanding <= credit_nxt;
      credit_error       <= error_nxt;
    end
  end

endmodule

// File: tb/tb_rx_credit_ctrl.sv
// Directed scoreboard bench for rx_credit_ctrl: a 64-deep and a 16-deep instance share
// link/reset, and sel routes the event pulses to one of them.
module tb_rx_credit_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, link, wr, rd, fs;
  bit   sel;

  logic       a_req, a_full, a_empty, a_err;
  logic [5:0] a_credit;
  logic [6:0] a_fifo;
  logic       b_req, b_full, b_empty, b_err;
  logic [5:0] b_credit;
  logic [4:0] b_fifo;

  rx_credit_ctrl #(.FIFO_DEPTH(64), .ADDR_WIDTH(6), .MAX_CREDIT(56)) dut_a (
    .negedge_clk        (clk),
    .rx_reset           (rst),
    .link_enable        (link),
    .rx_buffer_write    (wr && !sel),
    .rx_buffer_read     (rd && !sel),
    .fct_sent           (fs && !sel),
    .fct_request        (a_req),
    .credit_outstanding (a_credit),
    .fifo_used          (a_fifo),
    .rx_buffer_full     (a_full),
    .rx_buffer_empty    (a_empty),
    .credit_error       (a_err)
  );

  rx_credit_ctrl #(.FIFO_DEPTH(16), .ADDR_WIDTH(4), .MAX_CREDIT(56)) dut_b (
    .negedge_clk        (clk),
    .rx_reset           (rst),
    .link_enable        (link),
    .rx_buffer_write    (wr && sel),
    .rx_buffer_read     (rd && sel),
    .fct_sent           (fs && sel),
    .fct_request        (b_req),
    .credit_outstanding (b_credit),
    .fifo_used          (b_fifo),
    .rx_buffer_full     (b_full),
    .rx_buffer_empty    (b_empty),
    .credit_error       (b_err)
  );

  typedef struct {
    int         cyc;
    bit         dut;
    logic       req;
    logic [5:0] credit;
    logic [6:0] fifo;
    logic       err;
    bit         chk_err;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic w, input logic r, input logic f);
    wr = w;
    rd = r;
    fs = f;
    tick();
    wr = 1'b0;
    rd = 1'b0;
    fs = 1'b0;
  endtask

  // Expected state after the most recent edge; checked by the monitor mid-cycle.
  task automatic chk(input string name, input logic req, input int credit, input int fifo,
                     input logic err, input bit chk_err = 1'b1);
    exp_t e;
    e.cyc     = cyc;
    e.dut     = sel;
    e.req     = req;
    e.credit  = 6'(credit);
    e.fifo    = 7'(fifo);
    e.err     = err;
    e.chk_err = chk_err;
    e.name    = name;
    q.push_back(e);
  endtask

  exp_t       m_e;
  logic       m_req, m_full, m_empty, m_err, m_bad;
  logic [5:0] m_credit;
  logic [6:0] m_fifo;
  int         m_depth;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      if (m_e.dut) begin
        m_req = b_req; m_credit = b_credit; m_fifo = {2'b00, b_fifo};
        m_full = b_full; m_empty = b_empty; m_err = b_err; m_depth = 16;
      end else begin
        m_req = a_req; m_credit = a_credit; m_fifo = a_fifo;
        m_full = a_full; m_empty = a_empty; m_err = a_err; m_depth = 64;
      end
      m_bad = (m_req !== m_e.req) || (m_credit !== m_e.credit) || (m_fifo !== m_e.fifo)
           || (m_full !== (int'(m_e.fifo) == m_depth)) || (m_empty !== (m_e.fifo == 7'd0))
           || (m_e.chk_err && (m_err !== m_e.err));
      checks++;
      if (m_bad) begin
        failures++;
        $display("FAIL %s (dut %0d cyc %0d): got req=%0b credit=%0d fifo=%0d full=%0b empty=%0b err=%0b; want req=%0b credit=%0d fifo=%0d full=%0b empty=%0b err=%0b",
                 m_e.name, m_e.dut, cyc, m_req, m_credit, m_fifo, m_full, m_empty, m_err,
                 m_e.req, m_e.credit, m_e.fifo, int'(m_e.fifo) == m_depth, m_e.fifo == 7'd0,
                 m_e.err);
      end
    end
  end

  initial begin
    rst = 1'b1; link = 1'b0; wr = 1'b0; rd = 1'b0; fs = 1'b0; sel = 1'b0;
    tick();
    chk("reset", 0, 0, 0, 0);

    // Seven 8-char credits fit in 64 entries under the 56 ceiling.
    rst = 1'b0; link = 1'b1;
    tick();
    chk("link_up_idle", 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t1_req", 1, 8 * (k - 1), 0, 0);
      tick();
      chk("t1_req_hold", 1, 8 * (k - 1), 0, 0);
      step(0, 0, 1);
      chk("t1_grant", 0, 8 * k, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_cap_no_req", 0, 56, 0, 0);
    end
    step(0, 0, 1);
    chk("fct_sent_ignored", 0, 56, 0, 0);

    // Write with zero credit.
    link = 1'b0;
    tick();
    chk("t3_link_down", 0, 0, 0, 0);
    link = 1'b1;
    step(1, 0, 0);
    chk("t3_no_credit_write", 0, 0, 1, 1);
    tick();
    chk("t3_err_one_cycle", 1, 0, 1, 0);

    // Write and fct_sent on the same edge.
    step(0, 0, 1);
    chk("t4_grant8", 0, 8, 1, 0);
    tick();
    chk("t4_req", 1, 8, 1, 0);
    step(1, 0, 1);
    chk("t4_write_and_grant", 0, 15, 2, 0);
    tick();
    chk("t4_req_again", 1, 15, 2, 0);

    // Build credit 24 with data buffered, then drop the link mid-request.
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    chk("t6_writes", 1, 8, 9, 0);
    step(0, 0, 1);
    chk("t6_grant16", 0, 16, 9, 0);
    tick();
    chk("t6_req16", 1, 16, 9, 0);
    step(0, 0, 1);
    chk("t6_grant24", 0, 24, 9, 0);
    tick();
    chk("t6_req24", 1, 24, 9, 0);
    link = 1'b0;
    tick();
    chk("t6_link_drop", 0, 0, 9, 0);
    link = 1'b1;
    tick();
    chk("t6_reenable_idle", 0, 0, 9, 0);
    tick();
    chk("t6_reenable_req", 1, 0, 9, 0);
    rst = 1'b1;
    tick();
    chk("t6_reset_mid_request", 0, 0, 0, 0);
    rst = 1'b0;

    // Fill to full, overflow, write+read at full, drain, read while empty.
    for (int i = 0; i < 64; i++) step(1, 0, 0);
    chk("t5_full", 1, 0, 64, 1);
    step(1, 0, 0);
    chk("t5_overflow", 1, 0, 64, 1);
    tick();
    chk("t5_err_clear", 1, 0, 64, 0);
    step(1, 1, 0);
    chk("t5_write_read_full", 1, 0, 64, 0, 1'b0);
    step(0, 1, 0);
    chk("t5_read", 1, 0, 63, 0);
    for (int i = 0; i < 63; i++) step(0, 1, 0);
    chk("t5_drained", 1, 0, 0, 0);
    step(0, 1, 0);
    chk("t5_read_empty", 1, 0, 0, 0);

    // 16-deep instance: credit returns only once reads free enough space.
    sel = 1'b1;
    rst = 1'b1;
    tick();
    chk("t2_reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("t2_idle", 0, 0, 0, 0);
    tick();
    chk("t2_req1", 1, 0, 0, 0);
    step(0, 0, 1);
    chk("t2_grant8", 0, 8, 0, 0);
    tick();
    chk("t2_req2", 1, 8, 0, 0);
    step(0, 0, 1);
    chk("t2_grant16", 0, 16, 0, 0);
    tick();
    chk("t2_no_req_at_16", 0, 16, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    chk("t2_written8", 0, 8, 8, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    chk("t2_read7_no_req", 0, 8, 1, 0);
    step(0, 1, 0);
    chk("t2_read8", 0, 8, 0, 0);
    tick();
    chk("t2_req_after_reads", 1, 8, 0, 0);
    step(0, 0, 1);
    chk("t2_grant_back16", 0, 16, 0, 0);

    tick();
    tick();
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: pending=%0d required=0", q.size());
      failures += q.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_credit_ctrl.md
Name: rx_credit_ctrl

Overview:
- Receive-side flow-control manager for the SpaceWire RX buffer.
- Tracks RX FIFO occupancy and the N-char credit granted to the far end.
- Schedules FCT requests to the transmitter whenever buffer space allows another 8-char credit.
- Flags credit violations: an N-char arriving with no credit left, or a write into a full buffer.

Parameters:
FIFO_DEPTH, 64, number of N-char entries in the RX buffer (power of two, at least 8)
ADDR_WIDTH, 6, log2(FIFO_DEPTH)
MAX_CREDIT, 56, ceiling on outstanding credit (multiple of 8)

Ports:
negedge_clk  in  1  receive-side clock; all logic is on its rising edge
rx_reset  in  1  synchronous, active-high reset
link_enable  in  1  high while the link is in Connecting or Run; low clears credit state
rx_buffer_write  in  1  one-cycle pulse: one N-char (data, EOP or EEP) written to the RX buffer
rx_buffer_read  in  1  one-cycle pulse: host popped one entry (same clock domain)
fct_sent  in  1  one-cycle pulse from TX: the requested FCT has been transmitted
fct_request  out  1  level; asks TX to send one FCT
credit_outstanding  out  6  N-chars credited to the far end and not yet received
fifo_used  out  ADDR_WIDTH+1  current RX buffer occupancy
rx_buffer_full  out  1  fifo_used == FIFO_DEPTH
rx_buffer_empty  out  1  fifo_used == 0
credit_error  out  1  one-cycle pulse on a credit or overflow violation

Behaviour:
- Reset (rx_reset high at a clock edge): all outputs are 0 except rx_buffer_empty = 1; FSM goes to DISABLED. Reset overrides every other input in that cycle.
- Definitions: free = FIFO_DEPTH - fifo_used. eligible = (free >= credit_outstanding + 8) && (credit_outstanding + 8 <= MAX_CREDIT). eligible is computed from registered values only.
- FSM states:
  - DISABLED: fct_request = 0; credit_outstanding held at 0. Go to IDLE when link_enable = 1.
  - IDLE: when eligible, go to REQUEST; fct_request rises on that edge, so it is visible 1 cycle after eligibility.
  - REQUEST: fct_request held high. On fct_sent, credit_outstanding += 8, fct_request falls on the same edge, and the FSM returns to IDLE.
  - Minimum spacing between consecutive fct_request assertions is 1 low cycle.
- link_enable low in any state: next state DISABLED; fct_request = 0 and credit_outstanding = 0 next cycle. fifo_used is retained so buffered data stays readable.
- fct_sent outside REQUEST is ignored.
- rx_buffer_write:
  - fifo_used += 1 unless full.
  - Write while full: fifo_used unchanged and credit_error pulses.
  - credit_outstanding -= 1 if nonzero. If zero it stays 0 and credit_error pulses.
  - Write while link_enable = 0 also pulses credit_error.
- rx_buffer_read: fifo_used -= 1 unless empty; a read while empty is ignored with no error.
- Simultaneous events:
  - write + read: fifo_used unchanged (read considered first only when full, so no overflow error).
  - write + fct_sent in REQUEST: credit_outstanding net +7.
  - Violation + fct_sent: credit +8, the write decrements nothing, and the error is still flagged.
- Width: credit_outstanding never exceeds MAX_CREDIT and fifo_used never exceeds FIFO_DEPTH. A write is a 1-unit decrement; fct_sent is an 8-unit increment.
- Invariant: fifo_used + credit_outstanding <= FIFO_DEPTH at all times when no error has occurred.
- credit_error is registered: it is high exactly one cycle after the offending edge, per event.

Test Plan:
1. Reset, then link_enable = 1 with FIFO_DEPTH 64 and no writes; answer each fct_request with fct_sent 2 cycles later -> exactly 7 FCTs granted, credit_outstanding steps 8,16,…,56 and then fct_request stays 0.
2. FIFO_DEPTH 16, link up, 2 FCTs granted (credit 16); write 8 chars -> credit 8 and fifo_used 8, no new request; read 8 -> fct_request rises, and after fct_sent credit = 16.
3. Link up with credit_outstanding 0, single rx_buffer_write -> credit_error high for 1 cycle, fifo_used = 1, credit stays 0.
4. In REQUEST with credit 8, rx_buffer_write and fct_sent on the same edge -> credit_outstanding = 15, fct_request 0 next cycle.
5. Fill to fifo_used = FIFO_DEPTH, then write alone -> credit_error pulse and fifo_used unchanged; write + read together -> fifo_used unchanged, no error.
6. Drop link_enable while fct_request high with credit 24 -> next cycle fct_request 0, credit 0, fifo_used retained. Re-enable -> new request within 2 cycles. Assert rx_reset mid-REQUEST -> all outputs at reset values the next cycle.
